fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if_id_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit_pkg
// Purpose : Shared types and constants for the instruction-fetch slice:
//           FSM state encoding, the canonical NOP word and the default
//           reset PC.
// Ports   : none (package)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- what IF/ID presents out of reset
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
//------------------------------------------------------------------------------
// Module  : if_id_reg
// Purpose : IF/ID pipeline register. Priority: rst > clear > hold > load.
//           clear only drops the valid bit; the payload is kept so a bubble
//           costs no extra toggling.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           i_load           - capture {1, i_pc, i_instr}
//           i_clear          - invalidate (wins over i_hold)
//           i_hold           - freeze everything, including valid
//           i_pc, i_instr    - incoming fetch PC and instruction word
//           o_valid, o_pc, o_instr - registered IF/ID contents
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic        i_hold,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0000_0000;
      r_instr <= NOP_INSTR;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_valid <= r_valid;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit
// Purpose : Instruction fetch stage: PC register, FETCH/WAIT/HALT control,
//           pc+4 adder and the IF/ID register.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           next_pc, redirect     - next PC and taken-jump/branch flag
//           stall                 - hazard freeze of PC and IF/ID
//           imem_ready, imem_rdata- instruction memory response
//           imem_req, imem_addr   - instruction memory request
//           pc, pc4               - current fetch PC and pc+4 (combinational)
//           if_id_valid/pc/instr  - IF/ID register contents
//           halted                - unit is parked in HALT
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter bit          HALT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        halted
);

  logic [31:0]  r_pc;
  fetch_state_e r_state;

  logic [31:0]  w_pc_nxt;
  fetch_state_e w_state_nxt;
  logic         w_active;
  logic         w_load;
  logic         w_clear;
  logic         w_hold;

  assign w_active = (r_state != ST_HALT);

  // FETCH and WAIT share one datapath: WAIT only records that the current
  // address is still outstanding, the request stays up in both.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    if (!w_active) begin
      // Entry cycle already loaded the halting instruction; drop it now.
      w_clear = 1'b1;
    end else if (redirect) begin
      // Redirect beats stall and readiness; the in-flight word is wrong-path.
      w_pc_nxt    = next_pc;
      w_clear     = 1'b1;
      w_state_nxt = ST_FETCH;
    end else if (stall) begin
      // Any returned word is dropped and re-requested once the stall lifts.
      if (!imem_ready) begin
        w_state_nxt = ST_WAIT;
      end
    end else if (imem_ready) begin
      w_pc_nxt = next_pc;
      w_load   = 1'b1;
      if (HALT_EN && (next_pc == r_pc)) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_state_nxt = ST_FETCH;
      end
    end else begin
      w_clear     = 1'b1;
      w_state_nxt = ST_WAIT;
    end
  end

  assign w_hold = stall && w_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= ST_FETCH;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_hold  (w_hold),
    .i_pc    (r_pc),
    .i_instr (imem_rdata),
    .o_valid (if_id_valid),
    .o_pc    (if_id_pc),
    .o_instr (if_id_instr)
  );

  assign imem_req  = !rst && w_active;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc4       = r_pc + 32'd4;
  assign halted    = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Purpose : Scoreboard bench for fetch_unit. The driver applies one directed
//           vector per cycle and queues the expected post-edge state plus any
//           IF/ID word that should be freshly loaded; the monitor pops and
//           compares after every rising edge.
// Ports   : none
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_pc = '0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        halted;

  fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .pc4         (pc4),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic        req;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  exp_t  exp_q[$];
  ifid_t ifid_q[$];
  ifid_t last_ifid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // W(a): instruction word the fake memory returns for address a
  function automatic logic [31:0] w_of(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // One cycle: drive inputs on the falling edge, queue post-edge expectations.
  task automatic step(input logic r, input logic [31:0] nxt, input logic rd,
                      input logic st, input logic rdy, input logic [31:0] rdata,
                      input logic [31:0] e_pc, input logic e_v, input logic e_h,
                      input logic e_req);
    exp_t e;
    @(negedge clk);
    rst        = r;
    next_pc    = nxt;
    redirect   = rd;
    stall      = st;
    imem_ready = rdy;
    imem_rdata = rdata;
    e.pc  = e_pc;
    e.v   = e_v;
    e.h   = e_h;
    e.req = e_req;
    exp_q.push_back(e);
  endtask

  task automatic expect_load(input logic [31:0] a);
    ifid_t x;
    x.pc    = a;
    x.instr = w_of(a);
    ifid_q.push_back(x);
  endtask

  // Monitor
  initial begin
    logic rst_s, stall_s, redir_s;
    exp_t e;
    ifid_t x;
    last_ifid.pc    = '0;
    last_ifid.instr = C_NOP;
    forever begin
      @(posedge clk);
      rst_s   = rst;
      stall_s = stall;
      redir_s = redirect;
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("imem_addr", imem_addr, e.pc);
        check("pc4", pc4, e.pc + 32'd4);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.v});
        check("halted", {31'b0, halted}, {31'b0, e.h});
        check("imem_req", {31'b0, imem_req}, {31'b0, e.req});
        if (rst_s) begin
          check("rst_if_id_pc", if_id_pc, 32'h0);
          check("rst_if_id_instr", if_id_instr, C_NOP);
          last_ifid.pc    = '0;
          last_ifid.instr = C_NOP;
        end else if (if_id_valid && stall_s && !redir_s) begin
          check("held_if_id_pc", if_id_pc, last_ifid.pc);
          check("held_if_id_instr", if_id_instr, last_ifid.instr);
        end else if (if_id_valid) begin
          if (ifid_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_load: got pc %08h expected no load", if_id_pc);
          end else begin
            x = ifid_q.pop_front();
            check("if_id_pc", if_id_pc, x.pc);
            check("if_id_instr", if_id_instr, x.instr);
            last_ifid = x;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end, expected end before 100000");
    $fatal(1);
  end

  // Driver: step(rst, next_pc, redirect, stall, ready, rdata, pc, valid, halted, req)
  initial begin
    // reset
    step(1, 32'h0,  0, 0, 0, 32'h0,      32'h0,  0, 0, 0);
    step(1, 32'h0,  0, 0, 1, 32'h0,      32'h0,  0, 0, 0);
    // sequential fetch
    step(0, 32'h4,  0, 0, 1, w_of(32'h0), 32'h4,  1, 0, 1); expect_load(32'h0);
    step(0, 32'h8,  0, 0, 1, w_of(32'h4), 32'h8,  1, 0, 1); expect_load(32'h4);
    // memory wait at 8 for three cycles
    step(0, 32'hC,  0, 0, 0, 32'h0,      32'h8,  0, 0, 1);
    step(0, 32'hC,  0, 0, 0, 32'h0,      32'h8,  0, 0, 1);
    step(0, 32'hC,  0, 0, 0, 32'h0,      32'h8,  0, 0, 1);
    step(0, 32'hC,  0, 0, 1, w_of(32'h8), 32'hC,  1, 0, 1); expect_load(32'h8);
    step(0, 32'h10, 0, 0, 1, w_of(32'hC), 32'h10, 1, 0, 1); expect_load(32'hC);
    // redirect at 10 -> 40
    step(0, 32'h40, 1, 0, 1, w_of(32'h10), 32'h40, 0, 0, 1);
    step(0, 32'h44, 0, 0, 1, w_of(32'h40), 32'h44, 1, 0, 1); expect_load(32'h40);
    // redirect while memory not ready -> 20
    step(0, 32'h20, 1, 0, 0, 32'h0,       32'h20, 0, 0, 1);
    step(0, 32'h24, 0, 0, 1, w_of(32'h20), 32'h24, 1, 0, 1); expect_load(32'h20);
    // two stall cycles, then stall + redirect -> 80
    step(0, 32'h28, 0, 1, 1, w_of(32'h24), 32'h24, 1, 0, 1);
    step(0, 32'h28, 0, 1, 0, 32'h0,       32'h24, 1, 0, 1);
    step(0, 32'h80, 1, 1, 1, w_of(32'h24), 32'h80, 0, 0, 1);
    step(0, 32'h84, 0, 0, 1, w_of(32'h80), 32'h84, 1, 0, 1); expect_load(32'h80);
    // word returned during stall is dropped and re-fetched
    step(0, 32'h88, 0, 1, 1, w_of(32'h84), 32'h84, 1, 0, 1);
    step(0, 32'h88, 0, 0, 1, w_of(32'h84), 32'h88, 1, 0, 1); expect_load(32'h84);
    // halt on self-loop at 6C
    step(0, 32'h6C, 1, 0, 1, w_of(32'h88), 32'h6C, 0, 0, 1);
    step(0, 32'h6C, 0, 0, 1, w_of(32'h6C), 32'h6C, 1, 1, 0); expect_load(32'h6C);
    step(0, 32'h70, 0, 0, 1, w_of(32'h70), 32'h6C, 0, 1, 0);
    step(0, 32'h100,1, 0, 1, w_of(32'h70), 32'h6C, 0, 1, 0);
    step(1, 32'h0,  0, 0, 0, 32'h0,       32'h0,  0, 0, 0);
    // wrap of pc4, then reset while waiting
    step(0, 32'hFFFF_FFFC, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, 1);
    step(0, 32'h0,  0, 0, 0, 32'h0,       32'hFFFF_FFFC, 0, 0, 1);
    step(1, 32'h0,  0, 1, 1, 32'h0,       32'h0,  0, 0, 0);
    // unaligned next_pc passes straight through
    step(0, 32'h3,  0, 0, 1, w_of(32'h0), 32'h3,  1, 0, 1); expect_load(32'h0);
    step(0, 32'h7,  0, 0, 1, w_of(32'h3), 32'h7,  1, 0, 1); expect_load(32'h3);
    step(1, 32'h0,  0, 0, 0, 32'h0,       32'h0,  0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("ifid_q_drained", ifid_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
